sipo_rx: RTL

Serial-in parallel-out deserializer. It is the receive end of the bit-serial link driven by the MAC unit's parallel-to-serial transmit path. It assembles WIDTH serial bits, qualified by sin_valid and framed by sof, into a parallel word. A completed word is presented on pout with a one-cycle pout_valid strobe. Malformed frames are reported through a sticky error flag.

---
 rtl/sipo_rx_if.sv | 13 +
 rtl/sipo_rx.sv | 62 ++++++
 2 files changed

// File: rtl/sipo_rx_if.sv
// sipo_rx_if: serial receive link and parallel result bundle for sipo_rx
interface sipo_rx_if #(parameter int WIDTH = 6);
  logic             sin;
  logic             sin_valid;
  logic             sof;
  logic             err_clr;
  logic [WIDTH-1:0] pout;
  logic             pout_valid;
  logic             busy;
  logic             frame_err;
  modport master (output sin, sin_valid, sof, err_clr, input pout, pout_valid, busy, frame_err);
  modport slave  (input sin, sin_valid, sof, err_clr, output pout, pout_valid, busy, frame_err);
endinterface

// File: rtl/sipo_rx.sv
// sipo_rx: sof-framed serial-in parallel-out deserializer with sticky frame error
module sipo_rx #(
  parameter int WIDTH     = 6,
  parameter bit MSB_FIRST = 1
) (
  input logic      clk,
  input logic      rst,
  sipo_rx_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           r_state, w_state;
  logic [WIDTH-1:0] r_sr, w_sr, r_pout, w_pout, w_load, w_shift;
  logic [CW-1:0]    r_cnt, w_cnt;
  logic             r_pv, w_pv, r_err, w_err, w_last;
  assign w_load  = MSB_FIRST ? {{(WIDTH-1){1'b0}}, bus.sin} : {bus.sin, {(WIDTH-1){1'b0}}};
  assign w_shift = MSB_FIRST ? {r_sr[WIDTH-2:0], bus.sin} : {bus.sin, r_sr[WIDTH-1:1]};
  assign w_last  = r_cnt == CW'(WIDTH - 1);
  // registers for state, shift path, result word, strobe and error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_pout  <= '0;
      r_pv    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_sr    <= w_sr;
      r_cnt   <= w_cnt;
      r_pout  <= w_pout;
      r_pv    <= w_pv;
      r_err   <= w_err;
    end
  end
  // next state: sof always (re)starts a frame; an sof inside a frame is an abort
  always_comb begin
    w_state = r_state;
    w_sr    = r_sr;
    w_cnt   = r_cnt;
    w_pout  = r_pout;
    w_pv    = 1'b0;
    w_err   = r_err & ~bus.err_clr;
    if (bus.sin_valid && bus.sof) begin
      w_state = SHIFT;
      w_sr    = w_load;
      w_cnt   = CW'(1);
      w_err   = w_err | (r_state == SHIFT);
    end else if (bus.sin_valid && r_state == SHIFT) begin
      w_sr    = w_shift;
      w_cnt   = w_last ? '0 : r_cnt + CW'(1);
      w_state = w_last ? IDLE : SHIFT;
      w_pout  = w_last ? w_shift : r_pout;
      w_pv    = w_last;
    end
  end
  assign bus.pout       = r_pout;
  assign bus.pout_valid = r_pv;
  assign bus.busy       = r_state == SHIFT;
  assign bus.frame_err  = r_err;
endmodule
